// File: rtl/xor_serializer.sv
// XOR cipher output stage: latches a data word and a key word on the rising edges
// of their done flags, then shifts data^key out MSB first with valid/busy/done flags.
module xor_serializer #(
    parameter int DATA_SIZE = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEn,
    input  logic [DATA_SIZE-1:0] iData,
    input  logic                 iData_done,
    input  logic [DATA_SIZE-1:0] iKey,
    input  logic                 iKey_done,
    output logic                 oSerial,
    output logic                 oValid,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int CW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [DATA_SIZE-1:0] shreg, shreg_nx;
    logic [CW-1:0]        bitcnt, bitcnt_nx;
    logic [DATA_SIZE-1:0] data_q, data_q_nx;
    logic [DATA_SIZE-1:0] key_q, key_q_nx;
    logic                 data_ok, data_ok_nx;
    logic                 key_ok, key_ok_nx;
    logic                 data_prev, key_prev;
    logic                 data_rise, key_rise;
    logic [DATA_SIZE-1:0] data_eff, key_eff;

    assign data_rise = iData_done & ~data_prev;
    assign key_rise  = iKey_done & ~key_prev;

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bitcnt_nx  = bitcnt;
        data_q_nx  = data_q;
        key_q_nx   = key_q;
        data_ok_nx = data_ok;
        key_ok_nx  = key_ok;
        data_eff   = data_rise ? iData : data_q;
        key_eff    = key_rise ? iKey : key_q;

        case (state)
            IDLE: begin
                if (data_rise) begin
                    data_q_nx  = iData;
                    data_ok_nx = 1'b1;
                end
                if (key_rise) begin
                    key_q_nx  = iKey;
                    key_ok_nx = 1'b1;
                end
                // A rise this cycle counts as already latched, so both flags rising together start at once.
                if ((data_ok | data_rise) & (key_ok | key_rise)) begin
                    shreg_nx  = data_eff ^ key_eff;
                    bitcnt_nx = '0;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                shreg_nx  = {shreg[DATA_SIZE-2:0], 1'b0};
                bitcnt_nx = bitcnt + 1'b1;
                if (bitcnt == LAST_BIT) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                data_ok_nx = 1'b0;
                key_ok_nx  = 1'b0;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Edge history advances with iEn only, so a rise seen during a stall is not lost.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            data_q    <= '0;
            key_q     <= '0;
            data_ok   <= 1'b0;
            key_ok    <= 1'b0;
            data_prev <= 1'b0;
            key_prev  <= 1'b0;
        end else if (iEn) begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            bitcnt    <= bitcnt_nx;
            data_q    <= data_q_nx;
            key_q     <= key_q_nx;
            data_ok   <= data_ok_nx;
            key_ok    <= key_ok_nx;
            data_prev <= iData_done;
            key_prev  <= iKey_done;
        end
    end

    assign oValid  = (state == SHIFT);
    assign oBusy   = (state == SHIFT) || (state == DONE);
    assign oDone   = (state == DONE);
    assign oSerial = shreg[DATA_SIZE-1] & oValid;

endmodule

// File: doc/xor_serializer.md
Name: xor_serializer

Overview:
- Downstream stage of the serial-input deserializer in the XOR cipher datapath.
- Captures one deserialized data word and one deserialized key word. Each word arrives on its own done flag.
- Computes ciphertext as data XOR key, then shifts the result out serially, MSB first, with a per-bit valid and an end-of-word done pulse.
- Done flags from upstream are sticky levels, so this block acts on their rising edges only.

Parameters:
- DATA_SIZE, 4, width of data word, key word and ciphertext in bits (minimum 2).

Ports:
- iClk  input  1  system clock; all logic on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iEn  input  1  clock enable; when low, all internal state and outputs hold.
- iData  input  DATA_SIZE  parallel plaintext word from the data deserializer.
- iData_done  input  1  data deserializer done flag (level; may stay high).
- iKey  input  DATA_SIZE  parallel key word from the key deserializer.
- iKey_done  input  1  key deserializer done flag (level; may stay high).
- oSerial  output  1  ciphertext bit; 0 when oValid is low.
- oValid  output  1  high while oSerial carries a ciphertext bit.
- oBusy  output  1  high in SHIFT and DONE.
- oDone  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (synchronous, iRst=1 at a rising edge):
  - state=IDLE; shreg, bitcnt, data_q, key_q cleared.
  - data_ok, key_ok and the edge-detect history regs cleared to 0.
  - oSerial=0, oValid=0, oBusy=0, oDone=0.
  - Reset overrides everything, including mid-SHIFT: the word is abandoned and no oDone is issued.
- iEn=0: no register changes, including edge-detect history, so no rising edge is lost. Outputs hold their values.
- Edge detect:
  - data_rise = iData_done & ~data_prev; key_rise likewise.
  - data_prev and key_prev update only when iEn=1.
- IDLE:
  - On data_rise: data_q <= iData, data_ok <= 1. On key_rise: key_q <= iKey, key_ok <= 1.
  - Transition condition: (data_ok | data_rise) & (key_ok | key_rise), in the same edge.
  - On transition: shreg <= effective data XOR effective key, where effective = live input on a rise this cycle, otherwise the latched copy. Also bitcnt <= 0, state <= SHIFT.
  - Both rises in one cycle therefore start immediately.
- SHIFT:
  - oValid=1, oBusy=1, oSerial=shreg[DATA_SIZE-1].
  - First bit is visible the cycle after the transition edge.
  - Each enabled edge: shreg <= shreg<<1, bitcnt <= bitcnt+1.
  - When bitcnt==DATA_SIZE-1, state <= DONE. Exactly DATA_SIZE valid cycles when iEn is held high.
- DONE:
  - oDone=1, oBusy=1, oValid=0.
  - data_ok and key_ok cleared; next enabled edge returns to IDLE.
- Rises during SHIFT or DONE are ignored: not latched, word dropped. The history still updates, so a sticky flag cannot retrigger later.
- Ciphertext is a bitwise XOR of equal widths; no arithmetic carries.
- Latency from the second rise to the first valid bit: 1 cycle. Word period, back-to-back: DATA_SIZE+2 cycles (IDLE, SHIFT×N, DONE).
- oValid, oBusy and oDone are decoded from registered state; oSerial is the registered MSB gated by oValid. None of them is a glitchy combinational path from inputs.

Test Plan:
- Basic: DATA_SIZE=4, iData=1011 with iData_done rising at cycle 2, iKey=0110 with iKey_done rising at cycle 5 -> oValid high cycles 6–9, oSerial 1,1,0,1, oDone pulse cycle 10, oBusy cycles 6–10.
- Simultaneous: iData=1111, iKey=1010, both done flags rise at the same cycle N -> oSerial 0,1,0,1 at N+1..N+4, oDone at N+5.
- Sticky flags: both done flags held high for 30 cycles after one encryption -> exactly one oDone; no second word.
- Stall: during SHIFT of 1101 (data 1011, key 0110), iEn=0 for 3 cycles after the 2nd bit -> oSerial/oValid hold 1/1 for 3 cycles; sequence stays 1,1,0,1; oDone delayed by 3.
- Reset mid-operation: iRst=1 after 2 bits -> next cycle all outputs 0, state IDLE, no oDone. A fresh pair (0001, 0001) then yields 0,0,0,0 with oValid high for 4 cycles.
- Ignored rise: iKey_done toggles 0→1 during SHIFT -> current word unaffected, block returns to IDLE with key_ok=0 and waits for a new key rise.
